// File: rtl/seq_shift_add_mac.sv
// rtl/seq_shift_add_mac.sv - sequential shift-add multiplier-accumulator, BITS_PER_CYC multiplier bits per clock
module seq_shift_add_mac #(
   parameter int WIDTH        = 256,
   parameter int BITS_PER_CYC = 1,
   parameter int ACC_GUARD    = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [WIDTH-1:0]               a,
   input  logic [WIDTH-1:0]               b,
   input  logic                           signed_mode,
   input  logic                           acc_en,
   input  logic                           acc_clr,
   output logic                           busy,
   output logic                           done,
   output logic [2*WIDTH-1:0]             product,
   output logic [2*WIDTH+ACC_GUARD-1:0]   acc,
   output logic                           overflow
);

   localparam int N  = WIDTH / BITS_PER_CYC;
   localparam int PW = 2 * WIDTH;
   localparam int AW = PW + ACC_GUARD;
   localparam int CW = $clog2(N + 1);
   localparam int SW = WIDTH + BITS_PER_CYC;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  mcand_q, mcand_d;
   logic [PW-1:0]     p_q, p_d;
   logic              neg_q, neg_d;
   logic              sgn_q, sgn_d;
   logic              acc_en_q, acc_en_d;
   logic [PW-1:0]     product_q, product_d;
   logic [AW-1:0]     acc_q, acc_d;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;

   logic [WIDTH-1:0]  a_mag, b_mag;
   logic [SW-1:0]     pp, step_sum;
   logic [PW-1:0]     p_step, prod_res;
   logic [AW-1:0]     prod_ext, acc_sum;
   logic              acc_carry, acc_sovf;

   // Magnitudes stay W bits unsigned, so -2^(W-1) maps to 2^(W-1) exactly.
   assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
   assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

   // hi + mcand*digit never exceeds W+BPC bits, so no carry is lost.
   assign pp       = SW'(mcand_q) * SW'(p_q[BITS_PER_CYC-1:0]);
   assign step_sum = SW'(p_q[PW-1:WIDTH]) + pp;
   assign p_step   = {step_sum, p_q[WIDTH-1:BITS_PER_CYC]};

   assign prod_res = neg_q ? -p_q : p_q;
   assign prod_ext = sgn_q ? AW'($signed(prod_res)) : AW'(prod_res);
   assign {acc_carry, acc_sum} = {1'b0, acc_q} + {1'b0, prod_ext};
   assign acc_sovf = (acc_q[AW-1] == prod_ext[AW-1]) && (acc_sum[AW-1] != acc_q[AW-1]);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      p_d       = p_q;
      neg_d     = neg_q;
      sgn_d     = sgn_q;
      acc_en_d  = acc_en_q;
      product_d = product_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RUN;
               mcand_d  = a_mag;
               p_d      = {{WIDTH{1'b0}}, b_mag};
               neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
               sgn_d    = signed_mode;
               acc_en_d = acc_en;
               cnt_d    = '0;
            end
            if (acc_clr) begin
               acc_d = '0;
               ovf_d = 1'b0;
            end
         end
         S_RUN: begin
            p_d   = p_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) state_d = S_FIN;
         end
         S_FIN: begin
            state_d   = S_IDLE;
            product_d = prod_res;
            done_d    = 1'b1;
            if (acc_en_q) begin
               acc_d = acc_sum;
               if (sgn_q ? acc_sovf : acc_carry) ovf_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         mcand_q   <= '0;
         p_q       <= '0;
         neg_q     <= 1'b0;
         sgn_q     <= 1'b0;
         acc_en_q  <= 1'b0;
         product_q <= '0;
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         p_q       <= p_d;
         neg_q     <= neg_d;
         sgn_q     <= sgn_d;
         acc_en_q  <= acc_en_d;
         product_q <= product_d;
         acc_q     <= acc_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign busy     = (state_q == S_RUN) || (state_q == S_FIN);
   assign done     = done_q;
   assign product  = product_q;
   assign acc      = acc_q;
   assign overflow = ovf_q;

endmodule
